// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - shared types and default constants for the toggle decoder
//
// Purpose : FSM state encoding and default parameter values used by
//           toggle_decoder and its testbench.
// Contents: tff_state_e (STABLE, FILTER), TFF_DEBOUNCE_CYCLES_DEFAULT,
//           TFF_CNT_WIDTH_DEFAULT.
package tff_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    FILTER = 1'b1
  } tff_state_e;

  localparam int TFF_DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int TFF_CNT_WIDTH_DEFAULT       = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
//
// Purpose : bring an asynchronous level into the clk domain.
// Ports   : clk - system clock
//           rst - synchronous active-high reset, clears both flops
//           d   - asynchronous input
//           q   - synchronized output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/toggle_decoder.sv
// rtl/toggle_decoder.sv - debounced toggle-event decoder with valid/ready output
//
// Purpose : every accepted level change of t_in becomes one event. A change is
//           accepted once DEBOUNCE_CYCLES consecutive synchronized samples
//           differ from the current filtered level.
// Ports   : clk       - system clock, rising edge
//           rst       - synchronous active-high reset
//           t_in      - asynchronous toggle-encoded event line
//           evt_ready - consumer accepts the pending event
//           evt_valid - an accepted event is pending
//           level     - debounced level of t_in
//           evt_count - accepted events modulo 2^CNT_WIDTH
//           overrun   - sticky: event accepted while one was still pending
module toggle_decoder
  import tff_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = TFF_DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_WIDTH       = TFF_CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 t_in,
  input  logic                 evt_ready,
  output logic                 evt_valid,
  output logic                 level,
  output logic [CNT_WIDTH-1:0] evt_count,
  output logic                 overrun
);

  localparam int FCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_DONE = FCW'(DEBOUNCE_CYCLES);

  logic t_sync;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (t_in),
    .q   (t_sync)
  );

  tff_state_e           state_q;
  tff_state_e           state_d;
  logic [FCW-1:0]       fcnt_q;
  logic [FCW-1:0]       fcnt_d;
  logic [FCW-1:0]       fcnt_inc;
  logic                 mismatch;
  logic                 accept;
  logic                 level_d;
  logic                 valid_d;
  logic                 overrun_d;
  logic [CNT_WIDTH-1:0] count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STABLE;
      fcnt_q    <= '0;
      level     <= 1'b0;
      evt_valid <= 1'b0;
      evt_count <= '0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      level     <= level_d;
      evt_valid <= valid_d;
      evt_count <= count_d;
      overrun   <= overrun_d;
    end
  end

  // fcnt_q holds how many mismatching samples have been seen so far, so the
  // current sample is number fcnt_q+1; accept when that reaches DEBOUNCE_CYCLES.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    accept   = 1'b0;
    mismatch = (t_sync != level);
    fcnt_inc = fcnt_q + FCW'(1);

    case (state_q)
      STABLE: begin
        if (mismatch) begin
          if (DEBOUNCE_CYCLES == 1) begin
            accept = 1'b1;
          end else begin
            state_d = FILTER;
            fcnt_d  = FCW'(1);
          end
        end
      end
      FILTER: begin
        if (!mismatch) begin
          state_d = STABLE;
          fcnt_d  = '0;
        end else if (fcnt_inc == FILT_DONE) begin
          accept  = 1'b1;
          state_d = STABLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_inc;
        end
      end
      default: begin
        state_d = STABLE;
        fcnt_d  = '0;
      end
    endcase

    level_d = level ^ accept;
    count_d = evt_count + CNT_WIDTH'(accept);
    // A new acceptance always leaves an event pending; otherwise a completed
    // handshake drains it. evt_ready has no effect while nothing is pending.
    valid_d = accept | (evt_valid & ~evt_ready);
    // Overrun only when the earlier event is not being consumed this cycle.
    overrun_d = overrun | (accept & evt_valid & ~evt_ready);
  end

endmodule

// File: tb/tb_toggle_decoder.sv
// tb/tb_toggle_decoder.sv - self-checking bench for toggle_decoder
module tb_toggle_decoder;
  import tff_pkg::*;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       t_in;
  logic       evt_ready;
  logic       evt_valid;
  logic       level;
  logic [7:0] evt_count;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;

  toggle_decoder #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .t_in      (t_in),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .level     (level),
    .evt_count (evt_count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: t_in reaches the decision point two edges late; an event
  // is accepted once D consecutive delayed samples differ from the level.
  bit       m_pipe[2];
  bit       m_lvl;
  bit       m_valid;
  bit       m_ovr;
  int       m_run;
  bit [7:0] m_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge(input bit ti, input bit rd, input bit rs);
    bit ts;
    bit acc;
    if (rs) begin
      m_pipe[0] = 0; m_pipe[1] = 0;
      m_lvl = 0; m_valid = 0; m_ovr = 0; m_run = 0; m_cnt = 0;
    end else begin
      ts = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = ti;
      acc = 0;
      if (ts != m_lvl) begin
        m_run++;
        if (m_run == D) begin
          acc = 1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (acc) begin
        if (m_valid && !rd) m_ovr = 1;
        m_lvl   = !m_lvl;
        m_cnt   = m_cnt + 8'd1;
        m_valid = 1;
      end else if (m_valid && rd) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic tick();
    bit ti, rd, rs;
    ti = t_in; rd = evt_ready; rs = rst;
    @(posedge clk);
    model_edge(ti, rd, rs);
    #1;
    check("model_valid", int'(evt_valid), int'(m_valid));
    check("model_level", int'(level), int'(m_lvl));
    check("model_count", int'(evt_count), int'(m_cnt));
    check("model_overrun", int'(overrun), int'(m_ovr));
  endtask

  task automatic do_reset();
    rst = 1'b1; t_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit       rst;
    bit       t;
    bit       rdy;
    bit       ev;
    bit       lv;
    bit [7:0] cnt;
    bit       ov;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input bit r, input bit t, input bit rdy,
                         input bit ev, input bit lv, input bit [7:0] cnt, input bit ov);
    vec_t v;
    v.rst = r; v.t = t; v.rdy = rdy; v.ev = ev; v.lv = lv; v.cnt = cnt; v.ov = ov;
    tbl.push_back(v);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; t_in = 1'b0; evt_ready = 1'b1;

    // Reset, single event (edge 6), then a 3-cycle glitch after a fresh reset.
    add_vec(1, 0, 1, 0, 0, 0, 0);
    add_vec(1, 0, 1, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0, 0, 0);   // edge 1
    add_vec(0, 1, 1, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0, 0, 0);   // edge 5
    add_vec(0, 1, 1, 1, 1, 1, 0);   // edge 6: accepted
    add_vec(0, 1, 1, 0, 1, 1, 0);   // handshake done
    add_vec(0, 1, 1, 0, 1, 1, 0);
    add_vec(1, 0, 1, 0, 0, 0, 0);
    add_vec(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add_vec(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add_vec(0, 0, 1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; t_in = tbl[i].t; evt_ready = tbl[i].rdy;
      tick();
      check($sformatf("vec%0d_valid", i), int'(evt_valid), int'(tbl[i].ev));
      check($sformatf("vec%0d_level", i), int'(level), int'(tbl[i].lv));
      check($sformatf("vec%0d_count", i), int'(evt_count), int'(tbl[i].cnt));
      check($sformatf("vec%0d_overrun", i), int'(overrun), int'(tbl[i].ov));
    end

    // Overrun: two accepted toggles while the consumer stalls.
    do_reset();
    evt_ready = 1'b0;
    t_in = 1'b1;
    repeat (10) tick();
    t_in = 1'b0;
    repeat (10) tick();
    check("ovr_count", int'(evt_count), 2);
    check("ovr_valid", int'(evt_valid), 1);
    check("ovr_flag", int'(overrun), 1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("ovr_drain_valid", int'(evt_valid), 0);
    check("ovr_sticky", int'(overrun), 1);
    tick();
    check("ovr_sticky2", int'(overrun), 1);

    // Wrap of the event counter.
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      t_in = ~t_in;
      repeat (8) tick();
      if (i == 254) check("wrap_count_ff", int'(evt_count), 255);
    end
    check("wrap_count", int'(evt_count), 0);
    check("wrap_overrun", int'(overrun), 0);
    check("wrap_level", int'(level), 0);

    // Reset in the middle of filtering, t_in held high across it.
    do_reset();
    evt_ready = 1'b1;
    t_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("midrst_pre_valid", int'(evt_valid), 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_rst_level", int'(level), 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("midrst_edge%0d_valid", k), int'(evt_valid), (k == D + 2) ? 1 : 0);
    end
    check("midrst_count", int'(evt_count), 1);
    check("midrst_level", int'(level), 1);

    // Randomized stimulus against the model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int hold;
      hold = $urandom_range(1, 9);
      t_in = ~t_in;
      for (int c = 0; c < hold; c++) begin
        evt_ready = ($urandom_range(0, 3) != 0);
        rst = ($urandom_range(0, 199) == 0);
        tick();
      end
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/toggle_decoder.md
TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive sampled cycles a new t_in level must persist to be accepted (legal range 1..255).
REQ-002 Parameter CNT_WIDTH, default 8, width of the accepted-event counter.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 t_in  input  1  toggle-encoded event line, asynchronous to clk; each level change is one event.
REQ-006 evt_ready  input  1  consumer accepts the pending event.
REQ-007 evt_valid  output  1  an accepted event is pending.
REQ-008 level  output  1  filtered, debounced level of t_in.
REQ-009 evt_count  output  CNT_WIDTH  number of accepted events modulo 2^CNT_WIDTH.
REQ-010 overrun  output  1  sticky flag: an event was accepted while a previous one was still pending.

Function
REQ-011 t_in shall pass through a two-flop synchronizer; t_sync is the second flop output.
REQ-012 The FSM shall have exactly two states: STABLE and FILTER.
REQ-013 STABLE: if t_sync != level, go to FILTER with filter count 1; otherwise stay in STABLE.
REQ-014 FILTER: if t_sync == level, return to STABLE, clear the filter count and generate no event (glitch rejected).
REQ-015 FILTER: if t_sync != level and the filter count equals DEBOUNCE_CYCLES, accept the event; otherwise increment the filter count.
REQ-016 With DEBOUNCE_CYCLES = 1, STABLE shall accept directly on the first mismatch sample without entering FILTER.
REQ-017 On acceptance: level inverts, evt_count increments (wrapping from all-ones to 0), evt_valid becomes 1, and the FSM returns to STABLE.
REQ-018 Latency: evt_valid and the new level are visible after rising edge DEBOUNCE_CYCLES+2, counting as edge 1 the edge that first captures the new t_in value.
REQ-019 A t_in pulse held for fewer than DEBOUNCE_CYCLES+... sampled cycles (specifically, fewer than DEBOUNCE_CYCLES consecutive mismatching t_sync samples) shall produce no event and no output change.
REQ-020 Handshake: evt_valid stays 1 until a cycle with evt_valid && evt_ready; after that edge it clears.
REQ-021 If an acceptance coincides with a completing handshake, evt_valid shall remain 1 and overrun shall not be set.
REQ-022 If an acceptance occurs while evt_valid = 1 and evt_ready = 0, then overrun shall be set to 1, evt_valid shall remain 1, and evt_count shall still increment.
REQ-023 overrun shall clear only on rst.
REQ-024 evt_ready shall be ignored while evt_valid = 0.

Reset
REQ-025 While rst = 1 at a rising edge, the following shall be forced: both synchronizer flops to 0, level to 0, FSM to STABLE, filter count to 0, evt_valid to 0, evt_count to 0 and overrun to 0.
REQ-026 Reset asserted in FILTER shall discard the partial debounce; no event results from it.
REQ-027 If t_in is 1 when rst deasserts, the mismatch shall be treated as a normal toggle and yield one event after the REQ-018 latency.

Structure
REQ-028 Shared package tff_pkg shall hold the FSM state enum (STABLE, FILTER) and the default constants for DEBOUNCE_CYCLES and CNT_WIDTH.
REQ-029 The synchronizer shall be the sub-module sync_2ff (ports clk, rst, d, q), reset to 0; all other logic is inline.
REQ-030 The filter counter width shall be $clog2(DEBOUNCE_CYCLES+1).

Verification (DEBOUNCE_CYCLES = 4, CNT_WIDTH = 8)
REQ-031 Reset check: hold rst for 2 cycles with t_in = 0 -> evt_valid = 0, level = 0, evt_count = 0, overrun = 0.
REQ-032 Single event: drive t_in 0->1 and hold it, evt_ready = 1 -> evt_valid high for exactly 1 cycle after edge 6; level = 1; evt_count = 1.
REQ-033 Glitch rejection: drive t_in high for 3 cycles, then low -> evt_valid never rises; level = 0; evt_count = 0.
REQ-034 Overrun: evt_ready = 0, apply two accepted toggles 10 cycles apart -> evt_count = 2, evt_valid = 1, overrun = 1; then evt_ready = 1 for 1 cycle -> evt_valid = 0 and overrun stays 1.
REQ-035 Wrap: apply 256 accepted toggles with evt_ready = 1 -> evt_count = 0, overrun = 0, level back to its initial value.
REQ-036 Reset mid-filter: toggle t_in, assert rst at edge 4 for 1 cycle with t_in held at 1 -> no event before reset; exactly one event at edge DEBOUNCE_CYCLES+2 after rst deasserts; evt_count = 1.
